// File: rtl/rd_alu_issue.sv
// rtl/rd_alu_issue.sv - RV64I OP/OP-IMM issue stage: decode, drive ALU for one cycle, return registered result
module rd_alu_issue #(
  parameter int TAG_W   = 4,
  parameter int SHAMT_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req_valid_in,
  output logic             req_ready_o,
  input  logic [31:0]      instr_in,
  input  logic [63:0]      rs1_in,
  input  logic [63:0]      rs2_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic [63:0]      alu_a_o,
  output logic [63:0]      alu_b_o,
  output logic [3:0]       alu_op_o,
  input  logic [63:0]      alu_c_in,
  input  logic             alu_zero_in,
  input  logic             alu_carry_in,
  input  logic             alu_overflow_in,
  input  logic             alu_negative_in,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_in,
  output logic [63:0]      rsp_result_o,
  output logic [3:0]       rsp_flags_o,
  output logic             rsp_illegal_o,
  output logic [TAG_W-1:0] rsp_tag_o
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [5:0]  funct6;
  logic [3:0]  dec_op;
  logic [63:0] dec_b_raw;
  logic [63:0] dec_b;
  logic        dec_illegal;
  logic        dec_shift;
  logic        op_arith;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];
  assign funct6 = instr_in[31:26];

  always_comb begin
    dec_op      = OP_ADD;
    dec_b_raw   = rs2_in;
    dec_illegal = 1'b0;
    if (opcode == OPC_OP) begin
      dec_b_raw = rs2_in;
      case (funct3)
        3'b000: begin
          if (funct7 == F7_BASE)     dec_op = OP_ADD;
          else if (funct7 == F7_ALT) dec_op = OP_SUB;
          else                       dec_illegal = 1'b1;
        end
        3'b001: begin dec_op = OP_SLL; dec_illegal = (funct7 != F7_BASE); end
        3'b100: begin dec_op = OP_XOR; dec_illegal = (funct7 != F7_BASE); end
        3'b101: begin
          if (funct7 == F7_BASE)     dec_op = OP_SRL;
          else if (funct7 == F7_ALT) dec_op = OP_SRA;
          else                       dec_illegal = 1'b1;
        end
        3'b110: begin dec_op = OP_OR;  dec_illegal = (funct7 != F7_BASE); end
        3'b111: begin dec_op = OP_AND; dec_illegal = (funct7 != F7_BASE); end
        default: dec_illegal = 1'b1;
      endcase
    end else if (opcode == OPC_OP_IMM) begin
      // Low immediate bits double as the shamt field for the shift forms.
      dec_b_raw = {{52{instr_in[31]}}, instr_in[31:20]};
      case (funct3)
        3'b000: dec_op = OP_ADD;
        3'b100: dec_op = OP_XOR;
        3'b110: dec_op = OP_OR;
        3'b111: dec_op = OP_AND;
        3'b001: begin dec_op = OP_SLL; dec_illegal = (funct6 != 6'b000000); end
        3'b101: begin
          if (funct6 == 6'b000000)      dec_op = OP_SRL;
          else if (funct6 == 6'b010000) dec_op = OP_SRA;
          else                          dec_illegal = 1'b1;
        end
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      dec_illegal = 1'b1;
    end
  end

  assign dec_shift = (dec_op == OP_SLL) || (dec_op == OP_SRL) || (dec_op == OP_SRA);
  assign dec_b     = dec_shift ? {{(64-SHAMT_W){1'b0}}, dec_b_raw[SHAMT_W-1:0]} : dec_b_raw;
  assign op_arith  = (alu_op_o == OP_ADD) || (alu_op_o == OP_SUB);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_result_o  <= '0;
      rsp_flags_o   <= '0;
      rsp_illegal_o <= 1'b0;
      rsp_tag_o     <= '0;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      alu_op_o      <= OP_ADD;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_in && req_ready_o) begin
            req_ready_o <= 1'b0;
            rsp_tag_o   <= tag_in;
            if (dec_illegal) begin
              rsp_result_o  <= '0;
              rsp_flags_o   <= '0;
              rsp_illegal_o <= 1'b1;
              rsp_valid_o   <= 1'b1;
              state         <= RESP;
            end else begin
              alu_a_o  <= rs1_in;
              alu_b_o  <= dec_b;
              alu_op_o <= dec_op;
              state    <= EXEC;
            end
          end
        end
        EXEC: begin
          // ALU carry/overflow are meaningless outside ADD/SUB.
          rsp_result_o  <= alu_c_in;
          rsp_flags_o   <= {alu_negative_in, alu_overflow_in & op_arith,
                            alu_carry_in & op_arith, alu_zero_in};
          rsp_illegal_o <= 1'b0;
          rsp_valid_o   <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_ready_in) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_alu_issue.sv
// tb/tb_rd_alu_issue.sv - directed bench for rd_alu_issue with a behavioural ALU stub
module tb_rd_alu_issue;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] instr = '0;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic [3:0]  tag = '0;
  logic [63:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_carry, alu_ovf, alu_neg;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_illegal;
  logic [3:0]  rsp_tag;
  logic        force_cf = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rd_alu_issue #(.TAG_W(4), .SHAMT_W(6)) dut (
    .clk_in(clk), .rst_in(rst),
    .req_valid_in(req_valid), .req_ready_o(req_ready),
    .instr_in(instr), .rs1_in(rs1), .rs2_in(rs2), .tag_in(tag),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_c_in(alu_c), .alu_zero_in(alu_zero), .alu_carry_in(alu_carry),
    .alu_overflow_in(alu_ovf), .alu_negative_in(alu_neg),
    .rsp_valid_o(rsp_valid), .rsp_ready_in(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags),
    .rsp_illegal_o(rsp_illegal), .rsp_tag_o(rsp_tag)
  );

  // Behavioural 64-bit ALU; carry on SUB means "no borrow".
  logic [64:0] sum;
  always_comb begin
    sum       = '0;
    alu_c     = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = sum[63:0];
        alu_carry = sum[64];
        alu_ovf = (alu_a[63] == alu_b[63]) && (alu_c[63] != alu_a[63]);
      end
      OP_SUB: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
        alu_c = sum[63:0];
        alu_carry = sum[64];
        alu_ovf = (alu_a[63] != alu_b[63]) && (alu_c[63] != alu_a[63]);
      end
      OP_AND: alu_c = alu_a & alu_b;
      OP_OR:  alu_c = alu_a | alu_b;
      OP_XOR: alu_c = alu_a ^ alu_b;
      OP_SLL: alu_c = alu_a << alu_b[5:0];
      OP_SRL: alu_c = alu_a >> alu_b[5:0];
      OP_SRA: alu_c = $unsigned($signed(alu_a) >>> alu_b[5:0]);
      default: alu_c = '0;
    endcase
    if (force_cf) begin
      alu_carry = 1'b1;
      alu_ovf   = 1'b1;
    end
  end
  assign alu_zero = (alu_c == 64'd0);
  assign alu_neg  = alu_c[63];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Presents one request and returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] tg);
    @(negedge clk);
    check("req_ready_before_send", {63'd0, req_ready}, 64'd1);
    instr = ins; rs1 = a; rs2 = b; tag = tg; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [63:0] res, input logic [3:0] flg,
                            input logic ill, input logic [3:0] tg);
    check({name, "_valid"},   {63'd0, rsp_valid}, 64'd1);
    check({name, "_result"},  rsp_result, res);
    check({name, "_flags"},   {60'd0, rsp_flags}, {60'd0, flg});
    check({name, "_illegal"}, {63'd0, rsp_illegal}, {63'd0, ill});
    check({name, "_tag"},     {60'd0, rsp_tag}, {60'd0, tg});
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({name, "_drained"}, {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  task automatic legal_op(input string name, input logic [31:0] ins, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] tg, input logic [3:0] exp_op,
                          input logic [63:0] exp_b, input logic [63:0] res, input logic [3:0] flg);
    send(ins, a, b, tg);
    check({name, "_not_yet_valid"}, {63'd0, rsp_valid}, 64'd0);
    check({name, "_alu_op"}, {60'd0, alu_op}, {60'd0, exp_op});
    check({name, "_alu_a"}, alu_a, a);
    check({name, "_alu_b"}, alu_b, exp_b);
    @(posedge clk);
    #1 expect_rsp(name, res, flg, 1'b0, tg);
  endtask

  task automatic illegal_op(input string name, input logic [31:0] ins, input logic [3:0] tg);
    send(ins, 64'hDEAD_BEEF_0000_1111, 64'h5555, tg);
    expect_rsp(name, 64'd0, 4'b0000, 1'b1, tg);
  endtask

  logic [63:0] held_result;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_rsp_misc", {55'd0, rsp_flags, rsp_illegal, rsp_tag}, 64'd0);
    check("rst_alu", alu_a | alu_b | {60'd0, alu_op}, 64'd0);

    legal_op("add_ovf", 32'h002081B3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h1, OP_ADD,
             64'd1, 64'h8000_0000_0000_0000, 4'b1100);
    legal_op("sub_eq", 32'h402081B3, 64'h1234, 64'h1234, 4'h2, OP_SUB,
             64'h1234, 64'd0, 4'b0011);
    legal_op("srai63", 32'h43F0D193, 64'h8000_0000_0000_0000, 64'd7, 4'h3, OP_SRA,
             64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    legal_op("srli63", 32'h03F0D193, 64'h8000_0000_0000_0000, 64'd7, 4'h4, OP_SRL,
             64'd63, 64'd1, 4'b0000);
    legal_op("addi_m1", 32'hFFF08193, 64'd5, 64'd9, 4'h5, OP_ADD,
             64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 4'b0010);
    force_cf = 1'b1;
    legal_op("and_cf", 32'h0020F1B3, 64'hF0F0, 64'hFF00, 4'h6, OP_AND,
             64'hFF00, 64'hF000, 4'b0000);
    force_cf = 1'b0;
    legal_op("sll_41", 32'h002091B3, 64'd1, 64'h41, 4'h7, OP_SLL,
             64'd1, 64'd2, 4'b0000);

    illegal_op("ill_system", 32'h0000_0073, 4'h9);
    check("ill_alu_op_held", {60'd0, alu_op}, {60'd0, OP_SLL});
    illegal_op("ill_slt", 32'h0020A1B3, 4'hA);
    illegal_op("ill_mul", 32'h022081B3, 4'hB);
    illegal_op("ill_srai_f6", 32'h23F0D193, 4'hC);

    // Backpressure: response held, new requests ignored.
    send(32'h0020E1B3, 64'hF0, 64'h0F, 4'hD);
    @(posedge clk);
    #1 held_result = 64'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; instr = 32'h002081B3; rs1 = 64'd100; rs2 = 64'd1; tag = 4'hE;
      @(posedge clk);
      #1;
      check("bp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_ready_low", {63'd0, req_ready}, 64'd0);
      check("bp_result", rsp_result, held_result);
      check("bp_tag", {60'd0, rsp_tag}, 64'hD);
    end
    req_valid = 1'b0;
    expect_rsp("bp_or", 64'hFF, 4'b0000, 1'b0, 4'hD);

    // Reset while in EXEC drops the transaction.
    send(32'h002081B3, 64'd3, 64'd4, 4'hF);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_exec_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_exec_ready", {63'd0, req_ready}, 64'd1);
    check("rst_exec_alu_a", alu_a, 64'd0);
    @(posedge clk);
    #1 check("rst_exec_no_rsp", {63'd0, rsp_valid}, 64'd0);

    legal_op("xor_after_rst", 32'h0020C1B3, 64'hFF, 64'h0F, 4'h8, OP_XOR,
             64'h0F, 64'hF0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
